seg_scan_controller: RTL and testbench
======================================

// Module: seg_scan_controller
// PURPOSE
//  Time-multiplexes one shared active-low 7-segment bus across NUM_DIGITS common-anode digits.
//  Holds a double-buffered hex frame written through a valid/ready port by upstream counters.
//  Swaps the shadow frame into the active frame only at a frame boundary, so the display never tears.
//  Sits between the counter/datapath logic and the board seg/an pins; instantiates the hex decoder.
// PARAMETERS
//  CLK_HZ       100_000_000  input clock frequency
//  FRAME_HZ     1000         full-frame refresh rate; DIGIT_CYCLES = CLK_HZ/(FRAME_HZ*NUM_DIGITS)
//  NUM_DIGITS   8            digits scanned, legal 1..8
//  BLANK_CYCLES 16           anti-ghost dead time at the start of each digit slot; must be < DIGIT_CYCLES
// PORTS
//  clk            in   1        system clock, all logic on posedge
//  rst_n          in   1        asynchronous, active-low reset
//  enable         in   1        1 = scan, 0 = display dark
//  wr_valid       in   1        frame write request
//  wr_ready       out  1        shadow buffer free
//  wr_digits      in   4*ND     nibble i = hex value of digit i
//  wr_blank       in   ND       bit i = 1 keeps digit i dark
//  seg            out  7        segments g..a, active-low, registered
//  an             out  8        anodes, active-low, registered; bits >= NUM_DIGITS stay 1
//  frame_done     out  1        1-cycle pulse at the end of the last digit slot
// BEHAVIOUR
//  Reset values: seg=7'h7F, an=8'hFF, wr_ready=1, frame_done=0, idx=0, slot counter=0.
//  Reset values (buffers): active/shadow digits=0, active blank=all 1s, pending=0, state=IDLE.
//  FSM states:
//   IDLE:  an=FF, seg=7F. enable=1 -> BLANK with idx=0, counter=0.
//   BLANK: an=FF, seg=7F for BLANK_CYCLES cycles, then -> SHOW.
//   SHOW:  an[idx]=0 unless active_blank[idx]; seg=decode(active_digits[idx]), or 7F if blanked.
//   SHOW duration: DIGIT_CYCLES-BLANK_CYCLES cycles.
//   End of SHOW, idx<ND-1: idx++, -> BLANK.
//   End of SHOW, idx==ND-1: idx=0, frame_done=1 for one cycle, apply swap if pending, -> BLANK.
//  enable=0 in any state -> IDLE next cycle; an=FF that cycle; idx and counter cleared; no frame_done.
//  Outputs are registered: seg/an change one cycle after the state/idx change that causes them.
//  Write handshake:
//   Transfer when wr_valid & wr_ready. Shadow <= wr_digits/wr_blank; pending<=1; wr_ready=0 next cycle.
//   Pending & frame boundary -> active<=shadow, pending<=0, wr_ready=1 next cycle.
//   Pending & state IDLE -> swap on the next cycle.
//   wr_valid while wr_ready=0 is held off; upstream must keep its data stable.
//   A transfer in the boundary cycle itself is not swapped until the next boundary.
//  Slot counter width = $clog2(DIGIT_CYCLES); it saturates-free wraps at DIGIT_CYCLES-1.
//  Hex decode covers 0-F: A,b,C,d,E,F in standard shapes.
//  Elaboration check: error if BLANK_CYCLES >= DIGIT_CYCLES, NUM_DIGITS not in 1..8, or DIGIT_CYCLES < 2.
//  Reset mid-frame: all outputs return to reset values asynchronously; any pending shadow is discarded.
// STRUCTURE
//  Package seg_pkg: SEG_OFF=7'h7F, AN_OFF=8'hFF, state enum {IDLE,BLANK,SHOW}, 16-entry hex pattern table.
//  Sub-module hex_to_seg: combinational 4-bit -> 7-bit active-low decoder, using the seg_pkg table.
//  Top level: FSM, slot counter, idx register, two frame buffers, output registers.
// TESTING
//  Bench parameters: CLK_HZ=800, FRAME_HZ=10, ND=8, BLANK_CYCLES=2, giving DIGIT_CYCLES=10.
//  1 Reset, enable=1, no write: an=FF throughout (all digits blank).
//    Required: frame_done every 80 cycles; wr_ready=1.
//  2 Write digits=32'h7654_3210, blank=0 while IDLE, then enable.
//    Required: digit i shows an=~(1<<i) for 8 cycles after 2 dark cycles.
//    Required: seg for digit 0 is 7'h40; seg for digit 5 is 7'h12.
//  3 Mid-frame write of 32'hFFFF_FFFF at digit 3.
//    Required: digits 3..7 keep old values; wr_ready=0 until the boundary.
//    Required: next frame shows F (7'h0E) on every digit; wr_ready=1 the cycle after frame_done.
//  4 blank=8'b1010_1010: an never asserts bits 1,3,5,7.
//    Required: seg=7F during those slots; frame period unchanged at 80 cycles.
//  5 Drop enable during SHOW of digit 4.
//    Required: an=FF next cycle; no frame_done.
//    Required: re-enable restarts at digit 0 with a 2-cycle blank.
//  6 Assert rst_n=0 mid-SHOW with a pending write.
//    Required: seg=7F and an=FF immediately; after release wr_ready=1 and the display is all blank.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, scan states and the active-low hex pattern table
// used by the multiplexed seven-segment scanner.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_e;

    // Segment order is g..a (bit 6 = g), active-low; entry 15 is listed first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_controller_hex_to_seg.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg_scan_controller.sv
// Scans a double-buffered hex frame across NUM_DIGITS common-anode digits
// on one shared active-low segment bus, swapping frames only at frame boundaries.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int FRAME_HZ     = 1000,
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_digits,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    output logic [6:0]              seg,
    output logic [7:0]              an,
    output logic                    frame_done
);

    localparam int DIGIT_CYCLES = CLK_HZ / (FRAME_HZ * NUM_DIGITS);
    localparam int CW           = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST       = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]    IDX_LAST       = 3'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg_scan_controller: NUM_DIGITS must be in 1..8");
    end
    if (DIGIT_CYCLES < 2) begin : g_bad_digit_cycles
        $error("seg_scan_controller: DIGIT_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank_cycles
        $error("seg_scan_controller: BLANK_CYCLES must be below DIGIT_CYCLES");
    end

    scan_state_e             state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [4*NUM_DIGITS-1:0] active_digits_q, shadow_digits_q;
    logic [NUM_DIGITS-1:0]   active_blank_q, shadow_blank_q;
    logic                    pending_q;

    logic [6:0]              seg_q, seg_d;
    logic [7:0]              an_q, an_d;

    logic                    frameEnd;
    logic                    wrFire;
    logic                    doSwap;
    logic [3:0]              curDigit;
    logic                    curBlank;
    logic [6:0]              curSeg;

    assign frameEnd   = (state_q == SHOW) && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST) && enable;
    assign wrFire     = wr_valid && !pending_q;
    // A dark display (IDLE) can take the new frame at once; otherwise wait for the boundary.
    assign doSwap     = pending_q && (frameEnd || (state_q == IDLE));

    assign wr_ready   = !pending_q;
    assign frame_done = frameEnd;
    assign seg        = seg_q;
    assign an         = an_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d = '0;
                    cnt_d = '0;
                    if (BLANK_CYCLES > 0) state_d = BLANK;
                    else                  state_d = SHOW;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_BLANK_LAST) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                        if (BLANK_CYCLES > 0) state_d = BLANK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits_q <= '0;
            shadow_blank_q  <= '0;
            active_digits_q <= '0;
            active_blank_q  <= '1;
            pending_q       <= 1'b0;
        end else begin
            if (wrFire) begin
                shadow_digits_q <= wr_digits;
                shadow_blank_q  <= wr_blank;
            end
            if (doSwap) begin
                active_digits_q <= shadow_digits_q;
                active_blank_q  <= shadow_blank_q;
            end
            pending_q <= wrFire || (pending_q && !doSwap);
        end
    end

    always_comb begin
        curDigit = '0;
        curBlank = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                curDigit = active_digits_q[4*i +: 4];
                curBlank = active_blank_q[i];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .hex_i (curDigit),
        .seg_o (curSeg)
    );

    // Gating on enable darkens the anodes on the very next edge after enable drops.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (enable && (state_q == SHOW) && !curBlank) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = curSeg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed, table-driven bench for seg_scan_controller with a 10-cycle digit slot
// (2 dark + 8 lit) and an 80-cycle frame.
module tb_seg_scan_controller;

    localparam int ND = 8;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          wr_valid;
    logic          wr_ready;
    logic [31:0]   wr_digits;
    logic [7:0]    wr_blank;
    logic [6:0]    seg;
    logic [7:0]    an;
    logic          frame_done;

    seg_scan_controller #(
        .CLK_HZ       (800),
        .FRAME_HZ     (10),
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_digits  (wr_digits),
        .wr_blank   (wr_blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] an;
        logic [6:0] seg;
        logic       rdy;
        logic       fd;
    } vec_t;

    vec_t        vecs[$];
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  anHighMask;
    int          writeAt;
    logic [31:0] writeDigits;
    logic [7:0]  writeBlank;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input int k, input logic [7:0] a, input logic [6:0] s,
                          input logic r, input logic f);
        vec_t v;
        v.k = k; v.an = a; v.seg = s; v.rdy = r; v.fd = f;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [31:0] digits, input logic [7:0] blank);
        wr_valid  = 1'b1;
        wr_digits = digits;
        wr_blank  = blank;
    endtask

    task automatic goIdle();
        enable = 1'b0;
        tick();
        tick();
    endtask

    // Cycle k is sampled 1 time unit after the k-th clock edge counted from the call.
    task automatic runVectors(input int nCycles, input string tag, input int expFd);
        int viol   = 0;
        int fdSeen = 0;
        for (int k = 1; k <= nCycles; k++) begin
            tick();
            if ((an & anHighMask) != anHighMask) viol++;
            if (frame_done === 1'b1) fdSeen++;
            while (vecs.size() > 0 && vecs[0].k == k) begin
                checkOutput($sformatf("%s_k%0d_an", tag, k), 32'(an), 32'(vecs[0].an));
                checkOutput($sformatf("%s_k%0d_seg", tag, k), 32'(seg), 32'(vecs[0].seg));
                checkOutput($sformatf("%s_k%0d_rdy", tag, k), 32'(wr_ready), 32'(vecs[0].rdy));
                checkOutput($sformatf("%s_k%0d_fd", tag, k), 32'(frame_done), 32'(vecs[0].fd));
                void'(vecs.pop_front());
            end
            if (k == writeAt) applyStimulus(writeDigits, writeBlank);
            else if (k == writeAt + 1) wr_valid = 1'b0;
        end
        checkOutput({tag, "_an_mask_violations"}, 32'(viol), 32'd0);
        checkOutput({tag, "_frame_done_count"}, 32'(fdSeen), 32'(expFd));
        checkOutput({tag, "_vectors_unreached"}, 32'(vecs.size()), 32'd0);
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        wr_valid   = 1'b0;
        wr_digits  = '0;
        wr_blank   = '0;
        anHighMask = '0;
        writeAt    = -10;
        writeDigits = '0;
        writeBlank  = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_seg", 32'(seg), 32'h7F);
        checkOutput("reset_an", 32'(an), 32'hFF);
        checkOutput("reset_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Test 1: enabled with no write, everything stays dark.
        enable     = 1'b1;
        anHighMask = 8'hFF;
        addVec(1,   8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(79,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(80,  8'hFF, 7'h7F, 1'b1, 1'b1);
        addVec(81,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(159, 8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(160, 8'hFF, 7'h7F, 1'b1, 1'b1);
        addVec(161, 8'hFF, 7'h7F, 1'b1, 1'b0);
        runVectors(165, "t1", 2);
        goIdle();

        // Test 2: write while idle is swapped in on the next cycle.
        applyStimulus(32'h7654_3210, 8'h00);
        tick();
        checkOutput("t2_ready_after_write", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
        tick();
        checkOutput("t2_ready_after_idle_swap", 32'(wr_ready), 32'd1);

        // Tests 2 and 3: scan the frame, then overwrite mid-frame at digit 3.
        enable      = 1'b1;
        anHighMask  = 8'h00;
        writeAt     = 35;
        writeDigits = 32'hFFFF_FFFF;
        writeBlank  = 8'h00;
        addVec(3,   8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(4,   8'hFE, 7'h40, 1'b1, 1'b0);
        addVec(11,  8'hFE, 7'h40, 1'b1, 1'b0);
        addVec(12,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(13,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(14,  8'hFD, 7'h79, 1'b1, 1'b0);
        addVec(35,  8'hF7, 7'h30, 1'b1, 1'b0);
        addVec(36,  8'hF7, 7'h30, 1'b0, 1'b0);
        addVec(40,  8'hF7, 7'h30, 1'b0, 1'b0);
        addVec(45,  8'hEF, 7'h19, 1'b0, 1'b0);
        addVec(54,  8'hDF, 7'h12, 1'b0, 1'b0);
        addVec(61,  8'hDF, 7'h12, 1'b0, 1'b0);
        addVec(79,  8'h7F, 7'h78, 1'b0, 1'b0);
        addVec(80,  8'h7F, 7'h78, 1'b0, 1'b1);
        addVec(81,  8'h7F, 7'h78, 1'b1, 1'b0);
        addVec(82,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(84,  8'hFE, 7'h0E, 1'b1, 1'b0);
        addVec(144, 8'hBF, 7'h0E, 1'b1, 1'b0);
        addVec(160, 8'h7F, 7'h0E, 1'b1, 1'b1);
        runVectors(160, "t23", 2);
        writeAt = -10;
        goIdle();

        // Test 4: odd digits blanked.
        applyStimulus(32'h89AB_CDEF, 8'hAA);
        tick();
        wr_valid = 1'b0;
        tick();
        enable     = 1'b1;
        anHighMask = 8'hAA;
        addVec(5,   8'hFE, 7'h0E, 1'b1, 1'b0);
        addVec(15,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(24,  8'hFB, 7'h21, 1'b1, 1'b0);
        addVec(35,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(45,  8'hEF, 7'h03, 1'b1, 1'b0);
        addVec(64,  8'hBF, 7'h10, 1'b1, 1'b0);
        addVec(80,  8'hFF, 7'h7F, 1'b1, 1'b1);
        addVec(160, 8'hFF, 7'h7F, 1'b1, 1'b1);
        runVectors(160, "t4", 2);
        goIdle();

        // Test 5: drop enable while digit 4 is lit.
        enable = 1'b1;
        addVec(4,  8'hFE, 7'h0E, 1'b1, 1'b0);
        addVec(46, 8'hEF, 7'h03, 1'b1, 1'b0);
        runVectors(46, "t5on", 0);
        enable = 1'b0;
        tick();
        checkOutput("t5_an_after_disable", 32'(an), 32'hFF);
        checkOutput("t5_seg_after_disable", 32'(seg), 32'h7F);
        checkOutput("t5_fd_after_disable", 32'(frame_done), 32'd0);
        anHighMask = 8'hFF;
        runVectors(100, "t5off", 0);

        // Re-enable restarts at digit 0; test 6 then writes mid-SHOW and resets.
        enable      = 1'b1;
        anHighMask  = 8'hAA;
        writeAt     = 25;
        writeDigits = 32'h1111_1111;
        writeBlank  = 8'h00;
        addVec(1,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(2,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(3,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(4,  8'hFE, 7'h0E, 1'b1, 1'b0);
        addVec(25, 8'hFB, 7'h21, 1'b1, 1'b0);
        addVec(26, 8'hFB, 7'h21, 1'b0, 1'b0);
        addVec(27, 8'hFB, 7'h21, 1'b0, 1'b0);
        runVectors(27, "t5re", 0);
        writeAt = -10;

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_seg_in_reset", 32'(seg), 32'h7F);
        checkOutput("t6_an_in_reset", 32'(an), 32'hFF);
        checkOutput("t6_ready_in_reset", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t6_ready_after_release", 32'(wr_ready), 32'd1);
        anHighMask = 8'hFF;
        addVec(1,  8'hFF, 7'h7F, 1'b1, 1'b0);
        addVec(80, 8'hFF, 7'h7F, 1'b1, 1'b1);
        addVec(85, 8'hFF, 7'h7F, 1'b1, 1'b0);
        runVectors(90, "t6post", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
